axi_sram_dp_slave: RTL and testbench

AXI4 slave front end for the team's dual-port word SRAM. It converts AXI4 INCR/FIXED bursts into the RAM's independent write port (byte-enable `ram_wen`) and registered-address read port (`ram_ren`, data one cycle later). The read and write channels run fully in parallel, one per RAM port. It sits between the SoC interconnect and the RAM instance, driving all RAM ports itself.

---
 rtl/axi_sram_dp_slave.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_axi_sram_dp_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_dp_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_dp_slave
//
// AXI4 slave front end for a dual-port 32-bit word SRAM. The write channel
// drives the RAM write port (byte-enabled, written at the clock edge) and the
// read channel drives the registered-address read port (data one cycle after
// ram_ren). The two channels are fully independent and run in parallel.
//
// Ports
//   CLK, resetn              clock, synchronous active-low reset
//   s_aw*  (in) / s_awready  write address: id, byte address, len, burst
//   s_w*   (in) / s_wready   write data, byte strobes, last (ignored)
//   s_b*   (out) / s_bready  write response, always OKAY
//   s_ar*  (in) / s_arready  read address: id, byte address, len, burst
//   s_r*   (out) / s_rready  read data, id, resp (OKAY), last
//   ram_raddr, ram_ren (out), ram_rdata (in)      RAM read port
//   ram_waddr, ram_wdata, ram_wen (out)           RAM write port
// ---------------------------------------------------------------------------
module axi_sram_dp_slave #(
  parameter int AW  = 16,
  parameter int IDW = 4
) (
  input  logic           CLK,
  input  logic           resetn,
  // write address
  input  logic [IDW-1:0] s_awid,
  input  logic [31:0]    s_awaddr,
  input  logic [7:0]     s_awlen,
  input  logic [1:0]     s_awburst,
  input  logic           s_awvalid,
  output logic           s_awready,
  // write data
  input  logic [31:0]    s_wdata,
  input  logic [3:0]     s_wstrb,
  input  logic           s_wlast,
  input  logic           s_wvalid,
  output logic           s_wready,
  // write response
  output logic [IDW-1:0] s_bid,
  output logic [1:0]     s_bresp,
  output logic           s_bvalid,
  input  logic           s_bready,
  // read address
  input  logic [IDW-1:0] s_arid,
  input  logic [31:0]    s_araddr,
  input  logic [7:0]     s_arlen,
  input  logic [1:0]     s_arburst,
  input  logic           s_arvalid,
  output logic           s_arready,
  // read data
  output logic [IDW-1:0] s_rid,
  output logic [31:0]    s_rdata,
  output logic [1:0]     s_rresp,
  output logic           s_rlast,
  output logic           s_rvalid,
  input  logic           s_rready,
  // RAM read port
  output logic [AW-1:0]  ram_raddr,
  input  logic [31:0]    ram_rdata,
  output logic           ram_ren,
  // RAM write port
  output logic [AW-1:0]  ram_waddr,
  output logic [31:0]    ram_wdata,
  output logic [3:0]     ram_wen
);

  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_t;

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_t       w_state_q, w_state_d;
  logic           aw_ready_q, aw_ready_d;
  logic [IDW-1:0] w_id_q, w_id_d;
  logic [AW-1:0]  w_addr_q, w_addr_d;
  logic           w_fixed_q, w_fixed_d;
  logic [8:0]     w_cnt_q, w_cnt_d;

  logic aw_hs;
  logic w_hs;

  // awready is a flop so it stays low for the whole reset period and only
  // rises at the first edge after release.
  assign aw_hs = aw_ready_q & s_awvalid;
  assign w_hs  = (w_state_q == W_DATA) & s_wvalid;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_fixed_d = w_fixed_q;
    w_cnt_d   = w_cnt_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_id_d    = s_awid;
          w_addr_d  = s_awaddr[AW+1:2];
          w_fixed_d = (s_awburst == BURST_FIXED);
          w_cnt_d   = {1'b0, s_awlen} + 9'd1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // WRAP and reserved bursts advance like INCR
          if (!w_fixed_q) w_addr_d = w_addr_q + 1'b1;
          w_cnt_d = w_cnt_q - 9'd1;
          // burst length comes from awlen alone; wlast is not consulted
          if (w_cnt_q == 9'd1) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_fixed_q  <= 1'b0;
      w_cnt_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_fixed_q  <= w_fixed_d;
      w_cnt_q    <= w_cnt_d;
    end
  end

  assign s_awready = aw_ready_q;
  assign s_wready  = (w_state_q == W_DATA);
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bid     = w_id_q;
  assign s_bresp   = 2'b00;
  assign ram_waddr = w_addr_q;
  assign ram_wen   = w_hs ? s_wstrb : 4'h0;
  assign ram_wdata = w_hs ? s_wdata : 32'h0;

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_t       r_state_q, r_state_d;
  logic           ar_ready_q, ar_ready_d;
  logic [IDW-1:0] r_id_q, r_id_d;
  logic [AW-1:0]  r_addr_q, r_addr_d;
  logic           r_fixed_q, r_fixed_d;
  logic [8:0]     r_issue_cnt_q, r_issue_cnt_d;
  logic [8:0]     r_left_cnt_q, r_left_cnt_d;
  logic           inflight_q, inflight_d;
  logic [31:0]    fifo0_q, fifo0_d;
  logic [31:0]    fifo1_q, fifo1_d;
  logic           fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic           fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]     fifo_cnt_q, fifo_cnt_d;

  logic           ar_hs;
  logic           fifo_empty;
  logic           r_head_valid;
  logic [31:0]    r_head_data;
  logic           r_pop;
  logic           r_push;
  logic           fifo_pop;
  logic [1:0]     r_occupancy;
  logic           r_issue;

  assign ar_hs      = ar_ready_q & s_arvalid;
  assign fifo_empty = (fifo_cnt_q == 2'd0);

  // The word arriving from the RAM this cycle is presented directly when the
  // FIFO is empty, so a read costs only the RAM latency. It is pushed only if
  // it is not consumed on arrival.
  assign r_head_valid = ~fifo_empty | inflight_q;
  assign r_head_data  = !fifo_empty ? (fifo_rd_ptr_q ? fifo1_q : fifo0_q)
                      : (inflight_q ? ram_rdata : 32'h0);
  assign r_pop        = r_head_valid & s_rready;
  assign fifo_pop     = r_pop & ~fifo_empty;
  assign r_push       = inflight_q & ~(r_pop & fifo_empty);

  // Issue only while the buffered plus in-flight words leave room in the
  // 2-entry FIFO, so nothing the RAM returns can ever be dropped.
  assign r_occupancy = fifo_cnt_q + {1'b0, inflight_q};
  assign r_issue     = (r_state_q == R_BURST) && (r_issue_cnt_q != 9'd0) &&
                       (r_occupancy < 2'd2);

  always_comb begin
    r_state_d     = r_state_q;
    r_id_d        = r_id_q;
    r_addr_d      = r_addr_q;
    r_fixed_d     = r_fixed_q;
    r_issue_cnt_d = r_issue_cnt_q;
    r_left_cnt_d  = r_left_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_id_d        = s_arid;
          r_addr_d      = s_araddr[AW+1:2];
          r_fixed_d     = (s_arburst == BURST_FIXED);
          r_issue_cnt_d = {1'b0, s_arlen} + 9'd1;
          r_left_cnt_d  = {1'b0, s_arlen} + 9'd1;
          r_state_d     = R_BURST;
        end
      end
      R_BURST: begin
        if (r_issue) begin
          if (!r_fixed_q) r_addr_d = r_addr_q + 1'b1;
          r_issue_cnt_d = r_issue_cnt_q - 9'd1;
        end
        if (r_pop) begin
          r_left_cnt_d = r_left_cnt_q - 9'd1;
          if (r_left_cnt_q == 9'd1) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    inflight_d = r_issue;
  end

  // FIFO pointer and storage update; push and pop may share a cycle.
  always_comb begin
    fifo0_d       = fifo0_q;
    fifo1_d       = fifo1_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    if (r_push) begin
      if (fifo_wr_ptr_q) fifo1_d = ram_rdata;
      else               fifo0_d = ram_rdata;
      fifo_wr_ptr_d = ~fifo_wr_ptr_q;
    end
    if (fifo_pop) fifo_rd_ptr_d = ~fifo_rd_ptr_q;
    unique case ({r_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state_q     <= R_IDLE;
      ar_ready_q    <= 1'b0;
      r_id_q        <= '0;
      r_addr_q      <= '0;
      r_fixed_q     <= 1'b0;
      r_issue_cnt_q <= '0;
      r_left_cnt_q  <= '0;
      inflight_q    <= 1'b0;
      fifo0_q       <= '0;
      fifo1_q       <= '0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= '0;
    end else begin
      r_state_q     <= r_state_d;
      ar_ready_q    <= ar_ready_d;
      r_id_q        <= r_id_d;
      r_addr_q      <= r_addr_d;
      r_fixed_q     <= r_fixed_d;
      r_issue_cnt_q <= r_issue_cnt_d;
      r_left_cnt_q  <= r_left_cnt_d;
      inflight_q    <= inflight_d;
      fifo0_q       <= fifo0_d;
      fifo1_q       <= fifo1_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  assign s_arready = ar_ready_q;
  assign s_rvalid  = r_head_valid;
  assign s_rdata   = r_head_data;
  assign s_rid     = r_id_q;
  assign s_rresp   = 2'b00;
  // the head is always the oldest undelivered beat, so one remaining beat
  // means the head is the last one
  assign s_rlast   = r_head_valid & (r_left_cnt_q == 9'd1);
  assign ram_ren   = r_issue;
  assign ram_raddr = r_addr_q;

  // Address bits outside the word index and wlast carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_awaddr[31:AW+2], s_awaddr[1:0],
                       s_araddr[31:AW+2], s_araddr[1:0], s_wlast};

endmodule

// File: tb/tb_axi_sram_dp_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_dp_slave
//
// Drives AXI write and read bursts into axi_sram_dp_slave attached to a
// behavioural dual-port RAM. A word-array reference memory, updated from the
// AXI burst rules, produces expected read data pushed into a queue when each
// read is issued; independent monitors pop and compare R and B responses.
// ---------------------------------------------------------------------------
module tb_axi_sram_dp_slave;

  localparam int AW  = 16;
  localparam int IDW = 4;

  logic           CLK = 1'b0;
  logic           resetn;
  logic [IDW-1:0] s_awid;
  logic [31:0]    s_awaddr;
  logic [7:0]     s_awlen;
  logic [1:0]     s_awburst;
  logic           s_awvalid;
  logic           s_awready;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic           s_wlast;
  logic           s_wvalid;
  logic           s_wready;
  logic [IDW-1:0] s_bid;
  logic [1:0]     s_bresp;
  logic           s_bvalid;
  logic           s_bready;
  logic [IDW-1:0] s_arid;
  logic [31:0]    s_araddr;
  logic [7:0]     s_arlen;
  logic [1:0]     s_arburst;
  logic           s_arvalid;
  logic           s_arready;
  logic [IDW-1:0] s_rid;
  logic [31:0]    s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic           s_rvalid;
  logic           s_rready;
  logic [AW-1:0]  ram_raddr;
  logic [31:0]    ram_rdata = 32'h0;
  logic           ram_ren;
  logic [AW-1:0]  ram_waddr;
  logic [31:0]    ram_wdata;
  logic [3:0]     ram_wen;

  axi_sram_dp_slave #(.AW(AW), .IDW(IDW)) dut (
    .CLK(CLK), .resetn(resetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_ren(ram_ren),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM: registered read (old data on same-edge write), byte writes
  logic [31:0] ram_mem [0:65535];
  always @(posedge CLK) begin
    if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) ram_mem[ram_waddr][b*8 +: 8] = ram_wdata[b*8 +: 8];
  end

  // Reference model and scoreboard
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           last;
  } r_exp_t;

  logic [31:0]    ref_mem [0:65535];
  r_exp_t         r_exp [$];
  logic [IDW-1:0] b_exp [$];
  logic [31:0]    wr_data [$];
  logic [3:0]     wr_strb [$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  r_pops   = 0;
  int  mon_issued = 0;
  int  mon_hs     = 0;
  int  last_rlast_cyc = -1;
  bit  rd_active = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // R/B monitors and read-issue rules, sampled mid-cycle
  r_exp_t mon_e;
  logic [IDW-1:0] mon_bid;
  always @(negedge CLK) begin
    if (!resetn) begin
      mon_issued = 0;
      mon_hs     = 0;
    end else begin
      if (ram_ren) begin
        checkOutput("ren_outstanding_lt2", 64'((mon_issued - mon_hs) < 2), 64'd1);
        checkOutput("ren_only_in_burst", 64'(rd_active), 64'd1);
        mon_issued++;
      end
      if (s_rvalid && s_rready) begin
        if (r_exp.size() == 0) begin
          checkOutput("r_unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = r_exp.pop_front();
          checkOutput("rdata", 64'(s_rdata), 64'(mon_e.data));
          checkOutput("rid", 64'(s_rid), 64'(mon_e.id));
          checkOutput("rlast", 64'(s_rlast), 64'(mon_e.last));
          checkOutput("rresp", 64'(s_rresp), 64'd0);
        end
        if (s_rlast) last_rlast_cyc = cyc;
        r_pops++;
        mon_hs++;
      end
      if (s_bvalid && s_bready) begin
        if (b_exp.size() == 0) begin
          checkOutput("b_unexpected", 64'd1, 64'd0);
        end else begin
          mon_bid = b_exp.pop_front();
          checkOutput("bid", 64'(s_bid), 64'(mon_bid));
          checkOutput("bresp", 64'(s_bresp), 64'd0);
        end
      end
    end
  end

  // Reset pulse with reset-state and release checks
  task automatic applyReset();
    resetn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_awready", 64'(s_awready), 64'd0);
    checkOutput("rst_arready", 64'(s_arready), 64'd0);
    checkOutput("rst_wready", 64'(s_wready), 64'd0);
    checkOutput("rst_bvalid", 64'(s_bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(s_rvalid), 64'd0);
    checkOutput("rst_rlast", 64'(s_rlast), 64'd0);
    checkOutput("rst_ram_ren", 64'(ram_ren), 64'd0);
    checkOutput("rst_ram_wen", 64'(ram_wen), 64'd0);
    checkOutput("rst_ids_data", 64'({s_bid, s_rid, s_rdata}), 64'd0);
    checkOutput("rst_ram_bus", 64'({ram_raddr, ram_waddr, ram_wdata}), 64'd0);
    resetn = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rel_awready", 64'(s_awready), 64'd1);
    checkOutput("rel_arready", 64'(s_arready), 64'd1);
    checkOutput("rel_rvalid", 64'(s_rvalid), 64'd0);
  endtask

  // Write burst of wr_data/wr_strb; model updated from AXI burst rules
  task automatic applyWrite(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] burst,
                            input int bdelay);
    logic [15:0] w;
    int t;
    bit hs;
    w = addr[17:2];
    for (int i = 0; i <= len; i++) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[i][b]) ref_mem[w][b*8 +: 8] = wr_data[i][b*8 +: 8];
      if (burst != 2'd0) w = w + 16'd1;
    end
    b_exp.push_back(id);
    s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awburst = burst;
    s_awvalid = 1'b1;
    t = 0;
    do begin
      @(negedge CLK); hs = s_awready; @(posedge CLK); #1; t++;
    end while (!hs && t < 1000);
    s_awvalid = 1'b0;
    if (!hs) checkOutput("aw_timeout", 64'd0, 64'd1);
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge CLK); #1; end
      s_wdata = wr_data[i]; s_wstrb = wr_strb[i]; s_wlast = (i == len);
      s_wvalid = 1'b1;
      t = 0;
      do begin
        @(negedge CLK); hs = s_wready; @(posedge CLK); #1; t++;
      end while (!hs && t < 1000);
      s_wvalid = 1'b0;
      if (!hs) checkOutput("w_timeout", 64'd0, 64'd1);
    end
    checkOutput("bvalid_after_last_w", 64'(s_bvalid), 64'd1);
    repeat (bdelay) begin
      @(posedge CLK); #1;
      checkOutput("bvalid_held", 64'(s_bvalid), 64'd1);
    end
    s_bready = 1'b1;
    t = 0;
    do begin
      @(negedge CLK); hs = s_bvalid; @(posedge CLK); #1; t++;
    end while (!hs && t < 1000);
    s_bready = 1'b0;
    if (!hs) checkOutput("b_timeout", 64'd0, 64'd1);
    checkOutput("awready_after_b", 64'(s_awready), 64'd1);
  endtask

  // Read burst; mode 0 rready high, 1 toggling, 2 random.
  // abort_beats > 0 stops driving after that many beats (for reset tests).
  task automatic applyRead(input logic [IDW-1:0] id, input logic [31:0] addr,
                           input int len, input logic [1:0] burst,
                           input int mode, input int abort_beats);
    logic [15:0] w;
    r_exp_t e;
    int t, start, target, c0;
    bit hs;
    w = addr[17:2];
    for (int i = 0; i <= len; i++) begin
      e.id = id; e.data = ref_mem[w]; e.last = (i == len);
      r_exp.push_back(e);
      if (burst != 2'd0) w = w + 16'd1;
    end
    start  = r_pops;
    target = start + ((abort_beats > 0) ? abort_beats : len + 1);
    s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arburst = burst;
    s_arvalid = 1'b1;
    t = 0;
    do begin
      @(negedge CLK); hs = s_arready; @(posedge CLK); #1; t++;
    end while (!hs && t < 1000);
    s_arvalid = 1'b0;
    if (!hs) checkOutput("ar_timeout", 64'd0, 64'd1);
    c0 = cyc;
    rd_active = 1'b1;
    t = 0;
    while (r_pops < target && t < 2000) begin
      case (mode)
        0:       s_rready = 1'b1;
        1:       s_rready = ~s_rready;
        default: s_rready = 1'($urandom_range(0, 1));
      endcase
      @(posedge CLK); #1; t++;
    end
    s_rready = 1'b0;
    if (r_pops < target) checkOutput("r_timeout", 64'(r_pops - start), 64'(target - start));
    if (abort_beats == 0) begin
      rd_active = 1'b0;
      checkOutput("arready_after_last_r", 64'(s_arready), 64'd1);
      checkOutput("rvalid_after_burst", 64'(s_rvalid), 64'd0);
      if (mode == 0) checkOutput("rlast_cycle", 64'(last_rlast_cyc), 64'(c0 + 1 + len));
    end
  endtask

  task automatic fillRandom(input int len);
    wr_data.delete(); wr_strb.delete();
    for (int i = 0; i <= len; i++) begin
      wr_data.push_back($urandom);
      wr_strb.push_back(4'($urandom_range(0, 15)));
    end
  endtask

  int          rnd_len;
  logic [1:0]  rnd_burst;
  logic [31:0] rnd_addr;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 32'h0;
    resetn = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    for (int i = 0; i < 65536; i++) ram_mem[i] = 32'h0;

    applyReset();

    $display("[TB] single word write/read");
    wr_data = '{32'hDEADBEEF}; wr_strb = '{4'hF};
    applyWrite(4'h3, 32'h0000_0010, 0, 2'b01, 0);
    applyRead(4'h5, 32'h0000_0010, 0, 2'b01, 0, 0);

    $display("[TB] byte strobes over prefilled region");
    wr_data = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    wr_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    applyWrite(4'h1, 32'h0000_0100, 3, 2'b01, 1);
    wr_data = '{32'h0, 32'h1, 32'h2, 32'h3};
    wr_strb = '{4'h1, 4'h3, 4'hF, 4'h8};
    applyWrite(4'h2, 32'h0000_0100, 3, 2'b01, 0);
    applyRead(4'h7, 32'h0000_0100, 3, 2'b01, 0, 0);

    $display("[TB] INCR len 7 with toggling rready");
    fillRandom(7);
    applyWrite(4'h4, 32'h0000_0200, 7, 2'b01, 2);
    applyRead(4'h6, 32'h0000_0200, 7, 2'b01, 1, 0);

    $display("[TB] FIXED burst");
    wr_data = '{32'hA, 32'hB, 32'hC, 32'hD}; wr_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    applyWrite(4'h8, 32'h0000_0020, 3, 2'b00, 0);
    applyRead(4'h9, 32'h0000_0020, 0, 2'b01, 0, 0);
    applyRead(4'hA, 32'h0000_0024, 0, 2'b01, 0, 0);
    applyRead(4'hB, 32'h0000_0020, 2, 2'b00, 2, 0);

    $display("[TB] concurrent 16-beat read and write");
    fillRandom(15);
    applyWrite(4'hC, 32'h0000_0000, 15, 2'b01, 0);
    fillRandom(15);
    fork
      applyWrite(4'hD, 32'h0000_0400, 15, 2'b01, 5);
      applyRead(4'hE, 32'h0000_0000, 15, 2'b01, 2, 0);
    join
    applyRead(4'hF, 32'h0000_0400, 15, 2'b01, 0, 0);

    $display("[TB] address wrap and aliasing");
    fillRandom(1);
    applyWrite(4'h2, 32'h0003_FFFC, 1, 2'b01, 0);
    applyRead(4'h3, 32'hABC3_FFFC, 1, 2'b10, 2, 0);

    $display("[TB] random bursts");
    for (int k = 0; k < 6; k++) begin
      rnd_len   = $urandom_range(0, 7);
      rnd_burst = 2'($urandom_range(0, 3));
      rnd_addr  = $urandom;
      fillRandom(rnd_len);
      applyWrite(4'($urandom_range(0, 15)), rnd_addr, rnd_len, rnd_burst,
                 $urandom_range(0, 3));
      applyRead(4'($urandom_range(0, 15)), rnd_addr, rnd_len, rnd_burst, 2, 0);
    end

    $display("[TB] reset during read burst");
    applyRead(4'h9, 32'h0000_0200, 7, 2'b01, 0, 3);
    r_exp.delete();
    rd_active = 1'b0;
    applyReset();
    applyRead(4'h1, 32'h0000_0010, 0, 2'b01, 0, 0);

    checkOutput("r_exp_drained", 64'(r_exp.size()), 64'd0);
    checkOutput("b_exp_drained", 64'(b_exp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
